// File: rtl/hack_seq_ctrl_if.sv
// Hack sequencer memory-side handshake bundle.
// Instruction fetch port plus data read/write port.
interface hack_seq_ctrl_if;
   logic        imem_req;
   logic        imem_ack;
   logic [15:0] imem_rdata;
   logic        dmem_rd_req;
   logic        dmem_wr_req;
   logic        dmem_ack;

   modport master (
      output imem_req,
      output dmem_rd_req,
      output dmem_wr_req,
      input  imem_ack,
      input  imem_rdata,
      input  dmem_ack
   );

   modport slave (
      input  imem_req,
      input  dmem_rd_req,
      input  dmem_wr_req,
      output imem_ack,
      output imem_rdata,
      output dmem_ack
   );
endinterface

// File: rtl/hack_seq_ctrl.sv
// Hack CPU multi-cycle sequencer.
// Fetch, optional M read/write, then one commit cycle.
module hack_seq_ctrl #(
   parameter int ACK_TIMEOUT = 255,
   parameter int CNT_W       = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 run,
   hack_seq_ctrl_if.master      mem,
   output logic [15:0]          inst,
   input  logic                 zr,
   input  logic                 ng,
   output logic                 alu_sel_m,
   output logic                 a_load,
   output logic                 d_load,
   output logic                 pc_load,
   output logic                 pc_inc,
   output logic                 busy,
   output logic                 halted,
   output logic                 err,
   output logic [CNT_W-1:0]     retired
);

   localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_MEM_RD,
      S_MEM_WR,
      S_COMMIT,
      S_ERROR
   } state_t;

   state_t           state_q;
   logic [15:0]      inst_q;
   logic [CNT_W-1:0] ret_q;
   logic             err_q;
   logic [TW-1:0]    tmo_q;
   logic             ireq_q;
   logic             rreq_q;
   logic             wreq_q;

   logic             tmo_hit;
   logic             in_commit;
   logic             taken;

   // Timeout trips on the wait cycle that would bring the count to the limit.
   always_comb begin
      tmo_hit = 1'b0;
      if (ACK_TIMEOUT != 0)
         tmo_hit = (tmo_q == TW'(ACK_TIMEOUT - 1));
   end

   // Commit strobes decode the latched instruction and live ALU flags.
   always_comb begin
      in_commit = (state_q == S_COMMIT);
      taken     = inst_q[15] &
                  ((inst_q[2] & ng) |
                   (inst_q[1] & zr) |
                   (inst_q[0] & ~ng & ~zr));
      a_load    = in_commit & (~inst_q[15] | inst_q[5]);
      d_load    = in_commit & inst_q[15] & inst_q[4];
      pc_load   = in_commit & taken;
      pc_inc    = in_commit & ~taken;
   end

   // Sequencer FSM with registered requests, instruction and counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         inst_q  <= '0;
         ret_q   <= '0;
         err_q   <= 1'b0;
         tmo_q   <= '0;
         ireq_q  <= 1'b0;
         rreq_q  <= 1'b0;
         wreq_q  <= 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (run) begin
                  state_q <= S_FETCH;
                  ireq_q  <= 1'b1;
                  tmo_q   <= '0;
               end
            end
            S_FETCH: begin
               if (mem.imem_ack) begin
                  inst_q  <= mem.imem_rdata;
                  ireq_q  <= 1'b0;
                  state_q <= S_DECODE;
               end else if (tmo_hit) begin
                  ireq_q  <= 1'b0;
                  err_q   <= 1'b1;
                  state_q <= S_ERROR;
               end else begin
                  tmo_q <= tmo_q + TW'(1);
               end
            end
            S_DECODE: begin
               tmo_q <= '0;
               if (inst_q[15] & inst_q[12]) begin
                  rreq_q  <= 1'b1;
                  state_q <= S_MEM_RD;
               end else if (inst_q[15] & inst_q[3]) begin
                  wreq_q  <= 1'b1;
                  state_q <= S_MEM_WR;
               end else begin
                  state_q <= S_COMMIT;
               end
            end
            S_MEM_RD: begin
               if (mem.dmem_ack) begin
                  rreq_q <= 1'b0;
                  if (inst_q[3]) begin
                     wreq_q  <= 1'b1;
                     tmo_q   <= '0;
                     state_q <= S_MEM_WR;
                  end else begin
                     state_q <= S_COMMIT;
                  end
               end else if (tmo_hit) begin
                  rreq_q  <= 1'b0;
                  err_q   <= 1'b1;
                  state_q <= S_ERROR;
               end else begin
                  tmo_q <= tmo_q + TW'(1);
               end
            end
            S_MEM_WR: begin
               if (mem.dmem_ack) begin
                  wreq_q  <= 1'b0;
                  state_q <= S_COMMIT;
               end else if (tmo_hit) begin
                  wreq_q  <= 1'b0;
                  err_q   <= 1'b1;
                  state_q <= S_ERROR;
               end else begin
                  tmo_q <= tmo_q + TW'(1);
               end
            end
            S_COMMIT: begin
               ret_q <= ret_q + CNT_W'(1);
               if (run) begin
                  state_q <= S_FETCH;
                  ireq_q  <= 1'b1;
                  tmo_q   <= '0;
               end else begin
                  state_q <= S_IDLE;
               end
            end
            S_ERROR: begin
               state_q <= S_ERROR;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign mem.imem_req    = ireq_q;
   assign mem.dmem_rd_req = rreq_q;
   assign mem.dmem_wr_req = wreq_q;

   assign inst      = inst_q;
   assign alu_sel_m = inst_q[15] & inst_q[12];
   assign busy      = (state_q != S_IDLE) && (state_q != S_ERROR);
   assign halted    = (state_q == S_IDLE);
   assign err       = err_q;
   assign retired   = ret_q;

endmodule

// File: tb/tb_hack_seq_ctrl.sv
// Directed bench for the Hack sequencer.
// Memory acks are driven per cycle from the tasks.
module tb_hack_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        run = 1'b0;
   logic        zr = 1'b0;
   logic        ng = 1'b0;
   logic [15:0] inst;
   logic        alu_sel_m, a_load, d_load, pc_load, pc_inc;
   logic        busy, halted, err;
   logic [3:0]  retired;

   int          n_tests = 0;
   int          n_fail = 0;
   logic [3:0]  exp_ret = '0;

   int          lat, rdc, wrc, imc;
   logic        ovl, seen, c_a, c_d, c_pl, c_pi, c_sel;

   hack_seq_ctrl_if bus ();

   hack_seq_ctrl #(
      .ACK_TIMEOUT(4),
      .CNT_W(4)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .run(run),
      .mem(bus.master),
      .inst(inst),
      .zr(zr),
      .ng(ng),
      .alu_sel_m(alu_sel_m),
      .a_load(a_load),
      .d_load(d_load),
      .pc_load(pc_load),
      .pc_inc(pc_inc),
      .busy(busy),
      .halted(halted),
      .err(err),
      .retired(retired)
   );

   always #5 clk = ~clk;

   task automatic exec_inst(input logic [15:0] ins, input int rd_w,
                            input int wr_w, input logic z,
                            input logic n, input logic keep);
      bit done;
      done = 1'b0;
      lat = 0; rdc = 0; wrc = 0; imc = 0;
      ovl = 0; seen = 0;
      c_a = 0; c_d = 0; c_pl = 0; c_pi = 0; c_sel = 0;
      zr = z; ng = n; run = 1'b1;
      for (int k = 0; k < 4 && !bus.imem_req; k++) @(negedge clk);
      run = keep;
      for (int k = 0; k < 40 && !done; k++) begin
         bus.imem_ack = 1'b0;
         bus.dmem_ack = 1'b0;
         lat++;
         if (bus.dmem_rd_req && bus.dmem_wr_req) ovl = 1'b1;
         if (bus.imem_req) begin
            imc++;
            bus.imem_ack = 1'b1;
            bus.imem_rdata = ins;
         end
         if (bus.dmem_rd_req) begin
            rdc++;
            bus.dmem_ack = (rdc > rd_w);
         end
         if (bus.dmem_wr_req) begin
            wrc++;
            bus.dmem_ack = (wrc > wr_w);
         end
         if (a_load | d_load | pc_load | pc_inc) begin
            c_a = a_load; c_d = d_load;
            c_pl = pc_load; c_pi = pc_inc;
            c_sel = alu_sel_m;
            seen = 1'b1;
            done = 1'b1;
         end
         @(negedge clk);
      end
      bus.imem_ack = 1'b0;
      bus.dmem_ack = 1'b0;
      if (seen) exp_ret = exp_ret + 4'd1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #1;
      n_tests++;
      if ({bus.imem_req, bus.dmem_rd_req, bus.dmem_wr_req,
           a_load, d_load, pc_load, pc_inc, busy, halted, err} !== 10'b0000000010) begin
         n_fail++;
         $display("FAIL reset_ctl: got %b want 0000000010",
                  {bus.imem_req, bus.dmem_rd_req, bus.dmem_wr_req,
                   a_load, d_load, pc_load, pc_inc, busy, halted, err});
      end
      n_tests++;
      if ({inst, retired} !== 20'h0) begin
         n_fail++;
         $display("FAIL reset_regs: got %h want 00000", {inst, retired});
      end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      n_tests++;
      if (halted !== 1'b1 || bus.imem_req !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_no_run: got halted=%b req=%b want 1 0", halted, bus.imem_req);
      end
   endtask

   task automatic test_a_inst();
      exec_inst(16'h0005, 0, 0, 1'b0, 1'b0, 1'b0);
      n_tests++;
      if (lat !== 3 || seen !== 1'b1) begin
         n_fail++;
         $display("FAIL a_lat: got %0d seen=%b want 3 seen=1", lat, seen);
      end
      n_tests++;
      if ({c_a, c_d, c_pl, c_pi} !== 4'b1001) begin
         n_fail++;
         $display("FAIL a_strobes: got %b want 1001", {c_a, c_d, c_pl, c_pi});
      end
      n_tests++;
      if (rdc !== 0 || wrc !== 0 || imc !== 1) begin
         n_fail++;
         $display("FAIL a_reqs: got rd=%0d wr=%0d im=%0d want 0 0 1", rdc, wrc, imc);
      end
      n_tests++;
      if (retired !== 4'd1 || inst !== 16'h0005) begin
         n_fail++;
         $display("FAIL a_retire: got ret=%0d inst=%h want 1 0005", retired, inst);
      end
   endtask

   task automatic test_m_read();
      int extra;
      exec_inst(16'hFC10, 2, 0, 1'b0, 1'b0, 1'b0);
      n_tests++;
      if (rdc !== 3 || wrc !== 0) begin
         n_fail++;
         $display("FAIL rd_req_len: got rd=%0d wr=%0d want 3 0", rdc, wrc);
      end
      n_tests++;
      if (lat !== 6) begin
         n_fail++;
         $display("FAIL rd_lat: got %0d want 6", lat);
      end
      n_tests++;
      if ({c_sel, c_a, c_d, c_pl, c_pi} !== 5'b10101) begin
         n_fail++;
         $display("FAIL rd_strobes: got %b want 10101", {c_sel, c_a, c_d, c_pl, c_pi});
      end
      n_tests++;
      if (retired !== exp_ret) begin
         n_fail++;
         $display("FAIL rd_retire: got %0d want %0d", retired, exp_ret);
      end
      extra = 0;
      for (int k = 0; k < 3; k++) begin
         if (bus.imem_req || !halted) extra++;
         @(negedge clk);
      end
      n_tests++;
      if (extra !== 0) begin
         n_fail++;
         $display("FAIL run_stop: got %0d busy cycles want 0", extra);
      end
   endtask

   task automatic test_m_write();
      exec_inst(16'hE30F, 0, 1, 1'b0, 1'b0, 1'b0);
      n_tests++;
      if (rdc !== 0 || wrc !== 2 || lat !== 5) begin
         n_fail++;
         $display("FAIL wr_seq: got rd=%0d wr=%0d lat=%0d want 0 2 5", rdc, wrc, lat);
      end
      n_tests++;
      if ({c_sel, c_a, c_d, c_pl, c_pi} !== 5'b00010) begin
         n_fail++;
         $display("FAIL wr_strobes: got %b want 00010", {c_sel, c_a, c_d, c_pl, c_pi});
      end
   endtask

   task automatic test_jump();
      exec_inst(16'hE301, 0, 0, 1'b1, 1'b0, 1'b1);
      n_tests++;
      if ({c_pl, c_pi} !== 2'b01 || lat !== 3) begin
         n_fail++;
         $display("FAIL jgt_zero: got pl/pi=%b lat=%0d want 01 3", {c_pl, c_pi}, lat);
      end
      n_tests++;
      if (bus.imem_req !== 1'b1 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_fetch: got req=%b busy=%b want 1 1", bus.imem_req, busy);
      end
      exec_inst(16'hE301, 0, 0, 1'b0, 1'b0, 1'b0);
      n_tests++;
      if ({c_pl, c_pi} !== 2'b10 || lat !== 3) begin
         n_fail++;
         $display("FAIL jgt_pos: got pl/pi=%b lat=%0d want 10 3", {c_pl, c_pi}, lat);
      end
   endtask

   task automatic test_rd_wr();
      exec_inst(16'hFC0C, 0, 0, 1'b0, 1'b1, 1'b0);
      n_tests++;
      if (lat !== 5 || rdc !== 1 || wrc !== 1 || ovl !== 1'b0) begin
         n_fail++;
         $display("FAIL rdwr_seq: got lat=%0d rd=%0d wr=%0d ovl=%b want 5 1 1 0",
                  lat, rdc, wrc, ovl);
      end
      n_tests++;
      if ({c_a, c_d, c_pl, c_pi} !== 4'b0010) begin
         n_fail++;
         $display("FAIL jlt_neg: got %b want 0010", {c_a, c_d, c_pl, c_pi});
      end
      exec_inst(16'hEC20, 0, 0, 1'b0, 1'b1, 1'b0);
      n_tests++;
      if ({c_a, c_d, c_pl, c_pi} !== 4'b1001 || lat !== 3) begin
         n_fail++;
         $display("FAIL c_adest: got %b lat=%0d want 1001 3", {c_a, c_d, c_pl, c_pi}, lat);
      end
      n_tests++;
      if (retired !== exp_ret) begin
         n_fail++;
         $display("FAIL retire_cnt: got %0d want %0d", retired, exp_ret);
      end
   endtask

   task automatic test_reset_mid();
      run = 1'b1;
      zr = 1'b0;
      ng = 1'b0;
      for (int k = 0; k < 20 && !bus.dmem_wr_req; k++) begin
         bus.imem_ack = bus.imem_req;
         bus.imem_rdata = 16'hE308;
         @(negedge clk);
      end
      bus.imem_ack = 1'b0;
      n_tests++;
      if (bus.dmem_wr_req !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_wr_req: got %b want 1", bus.dmem_wr_req);
      end
      #2 rst_n = 1'b0;
      #1;
      n_tests++;
      if ({bus.imem_req, bus.dmem_rd_req, bus.dmem_wr_req, a_load, d_load,
           pc_load, pc_inc, busy, halted, err} !== 10'b0000000010) begin
         n_fail++;
         $display("FAIL mid_rst_ctl: got %b want 0000000010",
                  {bus.imem_req, bus.dmem_rd_req, bus.dmem_wr_req, a_load, d_load,
                   pc_load, pc_inc, busy, halted, err});
      end
      n_tests++;
      if ({inst, retired} !== 20'h0) begin
         n_fail++;
         $display("FAIL mid_rst_regs: got %h want 00000", {inst, retired});
      end
      run = 1'b0;
      exp_ret = '0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_wrap();
      int bad;
      bad = 0;
      for (int i = 0; i < 16; i++) begin
         exec_inst(16'(i), 0, 0, 1'b0, 1'b0, (i != 15));
         if (retired !== exp_ret || lat !== 3) bad++;
      end
      n_tests++;
      if (bad !== 0) begin
         n_fail++;
         $display("FAIL b2b_count: got %0d bad steps want 0", bad);
      end
      n_tests++;
      if (retired !== 4'd0 || halted !== 1'b1) begin
         n_fail++;
         $display("FAIL wrap: got ret=%0d halted=%b want 0 1", retired, halted);
      end
   endtask

   task automatic test_timeout();
      int bad;
      run = 1'b1;
      bus.imem_ack = 1'b0;
      for (int k = 0; k < 4 && !bus.imem_req; k++) @(negedge clk);
      imc = 0;
      for (int k = 0; k < 20 && bus.imem_req; k++) begin
         imc++;
         @(negedge clk);
      end
      n_tests++;
      if (imc !== 4) begin
         n_fail++;
         $display("FAIL tmo_len: got %0d req cycles want 4", imc);
      end
      n_tests++;
      if ({err, busy, halted, bus.imem_req} !== 4'b1000) begin
         n_fail++;
         $display("FAIL tmo_state: got %b want 1000", {err, busy, halted, bus.imem_req});
      end
      bad = 0;
      for (int k = 0; k < 6; k++) begin
         run = k[0];
         @(negedge clk);
         if (!err || busy || halted || bus.imem_req || bus.dmem_rd_req ||
             bus.dmem_wr_req || a_load || d_load || pc_load || pc_inc) bad++;
      end
      n_tests++;
      if (bad !== 0) begin
         n_fail++;
         $display("FAIL err_sticky: got %0d bad cycles want 0", bad);
      end
      run = 1'b0;
      rst_n = 1'b0;
      #1;
      n_tests++;
      if (err !== 1'b0 || halted !== 1'b1) begin
         n_fail++;
         $display("FAIL err_clear: got err=%b halted=%b want 0 1", err, halted);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      bus.imem_ack = 1'b0;
      bus.imem_rdata = '0;
      bus.dmem_ack = 1'b0;
      test_reset();
      test_a_inst();
      test_m_read();
      test_m_write();
      test_jump();
      test_rd_wr();
      test_reset_mid();
      test_wrap();
      test_timeout();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
